// File: rtl/execute_if.sv
// Execute-stage boundary: the E-stage bundle from decode, the stall handshake,
// and the E/M pipeline register presented to the memory stage.
interface execute_if #(
  parameter int WORD    = 32,
  parameter int REGADDR = 5
);
  logic               validE;
  logic [WORD-1:0]    rdata1E;
  logic [WORD-1:0]    rdata2E;
  logic [WORD-1:0]    immE;
  logic [WORD-1:0]    pcE;
  logic [REGADDR-1:0] rdE;
  logic [3:0]         ALUControlE;
  logic [1:0]         ALUSrcE;
  logic               regWriteE;
  logic               memWriteE;
  logic               mem2regE;
  logic               flushE;
  logic               stallM;
  logic               stallE;
  logic               validM;
  logic [WORD-1:0]    ALUResultM;
  logic [WORD-1:0]    writeDataM;
  logic [REGADDR-1:0] rdM;
  logic               regWriteM;
  logic               memWriteM;
  logic               mem2regM;

  modport slave (
    input  validE, rdata1E, rdata2E, immE, pcE, rdE, ALUControlE, ALUSrcE,
           regWriteE, memWriteE, mem2regE, flushE, stallM,
    output stallE, validM, ALUResultM, writeDataM, rdM, regWriteM, memWriteM, mem2regM
  );

  modport master (
    output validE, rdata1E, rdata2E, immE, pcE, rdE, ALUControlE, ALUSrcE,
           regWriteE, memWriteE, mem2regE, flushE, stallM,
    input  stallE, validM, ALUResultM, writeDataM, rdM, regWriteM, memWriteM, mem2regM
  );
endinterface

// File: rtl/execute.sv
// Execute stage: single-cycle ALU plus a shift-add multiplier that stalls the
// front end while it iterates, feeding the E/M pipeline register.
module execute #(
  parameter int WORD    = 32,
  parameter int REGADDR = 5
) (
  input  logic     clk,
  input  logic     reset,
  execute_if.slave e
);
  localparam int SHW = $clog2(WORD);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_PASB = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WORD-1:0]    prod_q, prod_d;
  logic [WORD-1:0]    mcand_q, mcand_d;
  logic [WORD-1:0]    mplier_q, mplier_d;

  logic               valid_q, valid_d;
  logic [WORD-1:0]    result_q, result_d;
  logic [WORD-1:0]    wdata_q, wdata_d;
  logic [REGADDR-1:0] rd_q, rd_d;
  logic               regwrite_q, regwrite_d;
  logic               memwrite_q, memwrite_d;
  logic               mem2reg_q, mem2reg_d;

  logic [WORD-1:0]    op_a, op_b, alu_res;
  logic [SHW-1:0]     shamt;
  logic               is_mul, mul_start, stall;

  assign op_a      = e.ALUSrcE[1] ? e.pcE  : e.rdata1E;
  assign op_b      = e.ALUSrcE[0] ? e.immE : e.rdata2E;
  assign shamt     = op_b[SHW-1:0];
  assign is_mul    = (e.ALUControlE == OP_MUL);
  assign mul_start = (state_q == IDLE) && e.validE && is_mul && !e.flushE;
  assign stall     = e.stallM || mul_start || (state_q == BUSY);
  assign e.stallE  = stall;

  // MUL is not handled here; its result comes from the product register in DONE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alu_res = '0;
    unique case (e.ALUControlE)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_SLT:  alu_res = {{(WORD-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(WORD-1){1'b0}}, op_a < op_b};
      OP_PASB: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    unique case (state_q)
      IDLE: begin
        if (mul_start && !e.stallM) begin
          state_d  = BUSY;
          mcand_d  = op_a;
          mplier_d = op_b;
          prod_d   = '0;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        if (e.flushE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == SHW'(WORD - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (e.flushE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!e.stallM) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A stalled memory stage freezes M; otherwise any stall or kill becomes a bubble.
  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    mem2reg_d  = mem2reg_q;
    if (!e.stallM) begin
      if (e.flushE || !e.validE || stall) begin
        valid_d    = 1'b0;
        result_d   = '0;
        wdata_d    = '0;
        rd_d       = '0;
        regwrite_d = 1'b0;
        memwrite_d = 1'b0;
        mem2reg_d  = 1'b0;
      end else begin
        valid_d    = 1'b1;
        result_d   = (state_q == DONE) ? prod_q : alu_res;
        wdata_d    = e.rdata2E;
        rd_d       = e.rdE;
        regwrite_d = e.regWriteE;
        memwrite_d = e.memWriteE;
        mem2reg_d  = e.mem2regE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      mem2reg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      mem2reg_q  <= mem2reg_d;
    end
  end

  assign e.validM     = valid_q;
  assign e.ALUResultM = result_q;
  assign e.writeDataM = wdata_q;
  assign e.rdM        = rd_q;
  assign e.regWriteM  = regwrite_q;
  assign e.memWriteM  = memwrite_q;
  assign e.mem2regM   = mem2reg_q;
endmodule

// File: tb/tb_execute.sv
// Bench for the execute stage: directed timing cases, then randomized traffic
// checked by a scoreboard against an arithmetic reference model.
module tb_execute;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [2:0]  ctl;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   rnd_stall = 1'b0;
  bit   prev_load = 1'b0;
  exp_t sb[$];
  exp_t m_exp, m_act;

  execute_if #(.WORD(32), .REGADDR(5)) bus ();

  execute #(.WORD(32), .REGADDR(5)) dut (
    .clk   (clk),
    .reset (reset),
    .e     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh = b[4:0];
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      4'd11: return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd, input logic [2:0] ctl);
    bus.validE      = 1'b1;
    bus.ALUControlE = op;
    bus.ALUSrcE     = src;
    bus.rdata1E     = a;
    bus.rdata2E     = b;
    bus.immE        = imm;
    bus.pcE         = pc;
    bus.rdE         = rd;
    {bus.regWriteE, bus.memWriteE, bus.mem2regE} = ctl;
    bus.flushE      = 1'b0;
  endtask

  task automatic alu_dir(input string name, input logic [3:0] op, input logic [1:0] src,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [31:0] exp);
    drive(op, src, a, b, imm, pc, 5'd1, 3'b100);
    cyc();
    bus.validE = 1'b0;
    check(name, bus.ALUResultM, exp);
    check({name, "_validM"}, 32'(bus.validM), 32'd1);
  endtask

  task automatic mul_dir(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         input bit stall_done);
    int bad;
    drive(OP_MUL, 2'b00, a, b, 32'd0, 32'd0, 5'd5, 3'b100);
    #1;
    check("mul_stallE_accept", 32'(bus.stallE), 32'd1);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (bus.stallE !== 1'b1 || bus.validM !== 1'b0) bad++;
    end
    check("mul_busy_window", 32'(bad), 32'd0);
    cyc();
    check("mul_done_stallE", 32'(bus.stallE), 32'd0);
    check("mul_done_validM", 32'(bus.validM), 32'd0);
    if (stall_done) begin
      bus.stallM = 1'b1;
      #1;
      bad = 0;
      repeat (3) begin
        if (bus.stallE !== 1'b1) bad++;
        cyc();
        if (bus.validM !== 1'b0) bad++;
      end
      check("mul_done_hold", 32'(bad), 32'd0);
      bus.stallM = 1'b0;
    end
    cyc();
    bus.validE = 1'b0;
    check("mul_result", bus.ALUResultM, exp);
    check("mul_validM", 32'(bus.validM), 32'd1);
    check("mul_rdM", 32'(bus.rdM), 32'd5);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Presents one instruction and holds it until it is consumed or killed.
  task automatic issue(input logic [3:0] op, input logic [1:0] src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd, input logic [2:0] ctl, input int abort_at);
    int   waited = 0;
    exp_t x;
    drive(op, src, a, b, imm, pc, rd, ctl);
    forever begin
      @(negedge clk);
      if (!bus.stallE) begin
        x.res   = model(op, src[1] ? pc : a, src[0] ? imm : b);
        x.wdata = b;
        x.rd    = rd;
        x.ctl   = ctl;
        sb.push_back(x);
        cyc();
        break;
      end
      if (waited == abort_at) begin
        bus.flushE = 1'b1;
        cyc();
        bus.flushE = 1'b0;
        break;
      end
      waited++;
      if (waited > 300) begin
        n_vec++;
        n_err++;
        $display("FAIL issue_timeout: stallE still 1 after %0d cycles, expected release", waited);
        bus.validE = 1'b0;
        cyc();
        break;
      end
      cyc();
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rnd_stall) bus.stallM = ($urandom_range(0, 3) == 0);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_load && bus.validM) begin
        m_act = '{res: bus.ALUResultM, wdata: bus.writeDataM, rd: bus.rdM,
                  ctl: {bus.regWriteM, bus.memWriteM, bus.mem2regM}};
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL mon_unexpected: got M entry res=%h rd=%0d, expected no entry", m_act.res, m_act.rd);
        end else begin
          m_exp = sb.pop_front();
          if (m_act !== m_exp) begin
            n_err++;
            $display("FAIL mon_entry: got res=%h wd=%h rd=%0d ctl=%b, expected res=%h wd=%h rd=%0d ctl=%b",
                     m_act.res, m_act.wdata, m_act.rd, m_act.ctl,
                     m_exp.res, m_exp.wdata, m_exp.rd, m_exp.ctl);
          end
        end
      end
      prev_load = !bus.stallM;
    end else begin
      prev_load = 1'b0;
    end
  end

  initial begin
    int bad;
    reset = 1'b1;
    bus.validE = 1'b0; bus.rdata1E = '0; bus.rdata2E = '0; bus.immE = '0; bus.pcE = '0;
    bus.rdE = '0; bus.ALUControlE = '0; bus.ALUSrcE = '0; bus.regWriteE = 1'b0;
    bus.memWriteE = 1'b0; bus.mem2regE = 1'b0; bus.flushE = 1'b0; bus.stallM = 1'b0;
    #1 reset = 1'b0;
    #2;
    check("rst_validM", 32'(bus.validM), 32'd0);
    check("rst_result", bus.ALUResultM, 32'd0);
    check("rst_wdata", bus.writeDataM, 32'd0);
    check("rst_rdM", 32'(bus.rdM), 32'd0);
    check("rst_ctl", 32'({bus.regWriteM, bus.memWriteM, bus.mem2regM}), 32'd0);
    check("rst_stallE", 32'(bus.stallE), 32'd0);
    #9 reset = 1'b1;
    cyc();

    drive(OP_ADD, 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0, 5'd7, 3'b100);
    cyc();
    bus.validE = 1'b0;
    check("add_result", bus.ALUResultM, 32'd2);
    check("add_rdM", 32'(bus.rdM), 32'd7);
    check("add_regWriteM", 32'(bus.regWriteM), 32'd1);
    check("add_validM", 32'(bus.validM), 32'd1);

    alu_dir("sra",   OP_SRA,  2'b00, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'hF800_0000);
    alu_dir("sltu",  OP_SLTU, 2'b00, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1);
    alu_dir("slt",   OP_SLT,  2'b00, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    alu_dir("auipc", OP_ADD,  2'b11, 32'd0, 32'd0, 32'h1000, 32'h100, 32'h1100);
    cyc();

    mul_dir(32'h1234_5678, 32'h10, 32'h2345_6780, 1'b0);
    cyc();
    mul_dir(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0);
    cyc();

    // Kill a MUL in flight; the front end must resume and the product must never appear.
    drive(OP_MUL, 2'b00, 32'h1234, 32'h5678, 32'd0, 32'd0, 5'd5, 3'b100);
    repeat (10) cyc();
    bus.flushE = 1'b1;
    cyc();
    bus.flushE = 1'b0;
    bus.validE = 1'b0;
    #1;
    check("flush_stallE", 32'(bus.stallE), 32'd0);
    check("flush_validM", 32'(bus.validM), 32'd0);
    drive(OP_ADD, 2'b00, 32'd2, 32'd3, 32'd0, 32'd0, 5'd2, 3'b100);
    #1;
    check("flush_idle_stallE", 32'(bus.stallE), 32'd0);
    cyc();
    bus.validE = 1'b0;
    check("flush_then_add", bus.ALUResultM, 32'd5);
    bad = 0;
    repeat (40) begin
      cyc();
      if (bus.validM !== 1'b0) bad++;
    end
    check("flush_no_product", 32'(bad), 32'd0);

    drive(OP_ADD, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 5'd3, 3'b100);
    cyc();
    drive(OP_SUB, 2'b00, 32'd9, 32'd4, 32'd0, 32'd0, 5'd9, 3'b100);
    bus.stallM = 1'b1;
    #1;
    bad = 0;
    repeat (3) begin
      if (bus.stallE !== 1'b1) bad++;
      cyc();
      if (bus.ALUResultM !== 32'd30 || bus.rdM !== 5'd3 || bus.validM !== 1'b1) bad++;
    end
    check("stallM_hold", 32'(bad), 32'd0);
    bus.stallM = 1'b0;
    cyc();
    bus.validE = 1'b0;
    check("stallM_release", bus.ALUResultM, 32'd5);
    check("stallM_release_rd", 32'(bus.rdM), 32'd9);
    cyc();

    mul_dir(32'd7, 32'd6, 32'd42, 1'b1);
    cyc();

    drive(OP_ADD, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0, 5'd4, 3'b100);
    cyc();
    bus.validE = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("async_rst_validM", 32'(bus.validM), 32'd0);
    check("async_rst_result", bus.ALUResultM, 32'd0);
    check("async_rst_rdM", 32'(bus.rdM), 32'd0);
    check("async_rst_regWriteM", 32'(bus.regWriteM), 32'd0);
    #2 reset = 1'b1;
    cyc();

    drive(OP_MUL, 2'b00, 32'hDEAD_BEEF, 32'h1111, 32'd0, 32'd0, 5'd5, 3'b100);
    repeat (5) cyc();
    #3;
    reset = 1'b0;
    bus.validE = 1'b0;
    #1;
    check("busy_rst_stallE", 32'(bus.stallE), 32'd0);
    check("busy_rst_validM", 32'(bus.validM), 32'd0);
    check("busy_rst_result", bus.ALUResultM, 32'd0);
    #2 reset = 1'b1;
    cyc();
    drive(OP_ADD, 2'b00, 32'd100, 32'd23, 32'd0, 32'd0, 5'd6, 3'b100);
    cyc();
    bus.validE = 1'b0;
    check("post_rst_add", bus.ALUResultM, 32'd123);
    check("post_rst_validM", 32'(bus.validM), 32'd1);
    cyc();
    mul_dir(32'd3, 32'd5, 32'd15, 1'b0);
    cyc();
    cyc();

    mon_en    = 1'b1;
    rnd_stall = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        bus.validE = 1'b0;
        bus.rdata1E = $urandom;
        cyc();
      end else if (r < 12) begin
        drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), rand_word(), rand_word(),
              rand_word(), $urandom, 5'($urandom), 3'($urandom));
        bus.flushE = 1'b1;
        cyc();
        bus.flushE = 1'b0;
      end else begin
        op = (r < 26) ? OP_MUL : 4'($urandom_range(0, 15));
        issue(op, 2'($urandom_range(0, 3)), rand_word(), rand_word(), rand_word(), $urandom,
              5'($urandom), 3'($urandom),
              (op == OP_MUL && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : -1);
      end
    end
    bus.validE = 1'b0;
    rnd_stall  = 1'b0;
    #2;
    bus.stallM = 1'b0;
    repeat (4) cyc();
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
